// File: rtl/pe_fifo_pkg.sv
// Shared definitions for the PE start-token FIFOs in the Linear_Layer dataflow region.
package pe_fifo_pkg;

  localparam int PE_START_DATA_WIDTH = 1;
  localparam int PE_START_ADDR_WIDTH = 1;
  localparam int PE_START_DEPTH      = 2;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // The count has to represent DEPTH itself, so it needs one bit more than the address.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/pe_start_srl_fifo_if.sv
// Producer/consumer handshake bundle of the PE start FIFO.
interface pe_start_srl_fifo_if
  import pe_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = PE_START_DATA_WIDTH,
  parameter int ADDR_WIDTH = PE_START_ADDR_WIDTH
);
  logic                               if_write_ce;
  logic                               if_write;
  logic [DATA_WIDTH-1:0]              if_din;
  logic                               if_full_n;
  logic                               if_read_ce;
  logic                               if_read;
  logic [DATA_WIDTH-1:0]              if_dout;
  logic                               if_empty_n;
  logic [count_width(ADDR_WIDTH)-1:0] if_count;

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_dout, if_empty_n, if_count
  );

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_dout, if_empty_n, if_count
  );
endinterface

// File: rtl/pe_start_srl_fifo_shiftreg.sv
// SRL-style storage: every write shifts the whole array by one, reads are an address mux.
module pe_start_srl_fifo_shiftreg #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] sig_q [DEPTH];
  logic [DATA_WIDTH-1:0] sig_d [DEPTH];

  always_comb begin
    sig_d = sig_q;
    if (we) begin
      sig_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        sig_d[i] = sig_q[i-1];
      end
    end
  end

  // NOTE: storage has no reset so it can map onto shift-register primitives; validity is tracked by the count.
  always_ff @(posedge clk) begin
    sig_q <= sig_d;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) dout = sig_q[i];
    end
  end

endmodule

// File: rtl/pe_start_srl_fifo.sv
// First-word-fall-through start-token FIFO: count, registered flags and push/pop handshake.
module pe_start_srl_fifo
  import pe_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = PE_START_DATA_WIDTH,
  parameter int ADDR_WIDTH = PE_START_ADDR_WIDTH,
  parameter int DEPTH      = PE_START_DEPTH
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  pe_start_srl_fifo_if.slave  bus
);

  localparam int CW = count_width(ADDR_WIDTH);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  push, pop;
  fifo_op_e              op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] dout;

  assign push = bus.if_write & bus.if_write_ce & full_n_q;
  assign pop  = bus.if_read  & bus.if_read_ce  & empty_n_q;
  assign op   = fifo_op_e'({push, pop});

  always_comb begin
    cnt_d = cnt_q;
    unique case (op)
      FIFO_PUSH: cnt_d = cnt_q + CW'(1);
      FIFO_POP:  cnt_d = cnt_q - CW'(1);
      default:   cnt_d = cnt_q;
    endcase
    empty_n_d = (cnt_d != '0);
    full_n_d  = (cnt_d != CW'(DEPTH));
  end

  // A push shifts the oldest word one slot deeper, so the address tracking it stays at cnt-1.
  assign addr = (cnt_q != '0) ? ADDR_WIDTH'(cnt_q - CW'(1)) : '0;

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_q     <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  pe_start_srl_fifo_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_shiftreg (
    .clk  (ap_clk),
    .we   (push),
    .addr (addr),
    .din  (bus.if_din),
    .dout (dout)
  );

  assign bus.if_dout    = dout;
  assign bus.if_full_n  = full_n_q;
  assign bus.if_empty_n = empty_n_q;
  assign bus.if_count   = cnt_q;

endmodule

// File: tb/tb_pe_start_srl_fifo.sv
// Randomised and directed bench for pe_start_srl_fifo against a queue-based FIFO model.
module tb_pe_start_srl_fifo;

  localparam int DW    = 8;
  localparam int AW    = 1;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference: the contents as a queue (front = oldest) plus the flags the spec prescribes.
  logic [DW-1:0] q[$];
  logic m_full_n  = 1'b0;
  logic m_empty_n = 1'b0;

  pe_start_srl_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pe_start_srl_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) u_dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance model across the edge, compare on the falling edge.
  task automatic step(input logic rst, input logic wce, input logic w, input logic [DW-1:0] din,
                      input logic rce, input logic r);
    logic do_push, do_pop;
    rst_n           = rst;
    bus.if_write_ce = wce;
    bus.if_write    = w;
    bus.if_din      = din;
    bus.if_read_ce  = rce;
    bus.if_read     = r;
    do_push = w & wce & m_full_n;
    do_pop  = r & rce & m_empty_n;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_full_n  = 1'b0;
      m_empty_n = 1'b0;
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(din);
      m_empty_n = (q.size() != 0);
      m_full_n  = (q.size() != DEPTH);
    end
    @(negedge clk);
    check("full_n",  bus.if_full_n,  m_full_n);
    check("empty_n", bus.if_empty_n, m_empty_n);
    check("count",   bus.if_count,   q.size());
    if (m_empty_n) check("dout", bus.if_dout, q[0]);
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1'b1, 1'b1, 1'b1, d, 1'b1, 1'b0);
  endtask

  task automatic pop();
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic both(input logic [DW-1:0] d);
    step(1'b1, 1'b1, 1'b1, d, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.if_write_ce = 1'b0;
    bus.if_write    = 1'b0;
    bus.if_din      = '0;
    bus.if_read_ce  = 1'b0;
    bus.if_read     = 1'b0;

    // Reset held with a write request present
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    check("rst_full_n",  bus.if_full_n,  1'b0);
    check("rst_empty_n", bus.if_empty_n, 1'b0);
    check("rst_count",   bus.if_count,   2'd0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    check("release_full_n", bus.if_full_n, 1'b1);

    // Fill and drain
    push(8'hA1);
    push(8'hB2);
    check("fill_count",  bus.if_count,  2'd2);
    check("fill_full_n", bus.if_full_n, 1'b0);
    push(8'hC3);
    check("overflow_count", bus.if_count, 2'd2);
    check("overflow_dout",  bus.if_dout,  8'hA1);
    pop();
    check("drain_dout_b2", bus.if_dout, 8'hB2);
    pop();
    check("drain_empty_n", bus.if_empty_n, 1'b0);

    // Fall-through latency
    push(8'h5E);
    check("ft_empty_n", bus.if_empty_n, 1'b1);
    check("ft_dout",    bus.if_dout,    8'h5E);
    pop();
    check("ft_pop_empty_n", bus.if_empty_n, 1'b0);

    // Simultaneous push and pop with one word held
    push(8'h11);
    both(8'h22);
    check("both_count", bus.if_count, 2'd1);
    check("both_dout",  bus.if_dout,  8'h22);
    for (int k = 0; k < 10; k++) both(8'h30 + 8'(k));
    check("stream_dout", bus.if_dout, 8'h39);
    pop();

    // Full with both requests: pop wins, push dropped
    push(8'h01);
    push(8'h02);
    both(8'h03);
    check("full_both_count",  bus.if_count,  2'd1);
    check("full_both_dout",   bus.if_dout,   8'h02);
    check("full_both_full_n", bus.if_full_n, 1'b1);

    // Read clock enable low blocks the pop
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("rce_count", bus.if_count, 2'd1);
    // Write clock enable low blocks the push
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    check("wce_count", bus.if_count, 2'd1);
    push(8'h44);
    check("mid_count", bus.if_count, 2'd2);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    check("midrst_count",   bus.if_count,   2'd0);
    check("midrst_empty_n", bus.if_empty_n, 1'b0);
    check("midrst_full_n",  bus.if_full_n,  1'b1);

    // Randomised traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, 8'($urandom),
           ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pe_start_srl_fifo.md
Name: pe_start_srl_fifo

Overview:
- SRL-based first-word-fall-through FIFO that carries start tokens (or narrow control words) from a producer task to a PE task in the Linear_Layer dataflow region.
- Wraps a shift-register storage array with pointer, full/empty flag and handshake control.
- The upstream task writes into it. The downstream PE pops one token per start.

Parameters:
- DATA_WIDTH, 1, width of each stored word.
- ADDR_WIDTH, 1, storage index width. Must satisfy DEPTH <= 2**ADDR_WIDTH.
- DEPTH, 2, number of storable words. Must be >= 1.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- if_write_ce  in  1  write-side clock enable.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  high = space available.
- if_read_ce  in  1  read-side clock enable.
- if_read  in  1  consumer pop request.
- if_dout  out  DATA_WIDTH  oldest stored word (fall-through).
- if_empty_n  out  1  high = if_dout valid.
- if_count  out  ADDR_WIDTH+1  number of words currently held, 0..DEPTH.

Behaviour:
- Accepted push: push = if_write & if_write_ce & if_full_n.
- Accepted pop: pop = if_read & if_read_ce & if_empty_n.
- Requests made while the matching flag is low are ignored. There are no side effects.
- Storage: SRL_SIG[0..DEPTH-1], not reset.
  - On push: SRL_SIG[i+1] <= SRL_SIG[i] for all i; SRL_SIG[0] <= if_din.
  - Pop alone does not move data.
- Count register cnt, width ADDR_WIDTH+1:
  - push & !pop: cnt+1.
  - pop & !push: cnt-1.
  - both or neither: hold.
- Read address: addr = cnt-1, truncated to ADDR_WIDTH, when cnt > 0. Otherwise addr = 0.
- if_dout = SRL_SIG[addr], combinational (fall-through).
  - Zero-latency from a registered address: a word pushed at edge N is visible on if_dout, with if_empty_n=1, after edge N.
  - Push-to-pop throughput is 1 per cycle.
- Flags are registered and computed from the next count:
  - if_empty_n <= (cnt_next != 0).
  - if_full_n <= (cnt_next != DEPTH).
  - if_count = cnt.
- Simultaneous push & pop when 0 < cnt < DEPTH: data shifts and addr is unchanged, so if_dout becomes the next-oldest word. Count and flags hold.
- Simultaneous push & pop when full: pop is accepted, push is rejected (full_n=0). Count becomes DEPTH-1. Next cycle full_n=1.
- Simultaneous push & pop when empty: pop is rejected, push is accepted. Count becomes 1.
- Clock enables: if_write_ce=0 suppresses push and if_read_ce=0 suppresses pop, independently. Flags still update from whichever event remains.
- Reset (ap_rst_n=0 sampled at an edge):
  - cnt=0, if_empty_n=0, if_full_n=0 (writes blocked while in reset).
  - The first edge with ap_rst_n=1 sets if_full_n=1.
  - Reset mid-operation discards all contents. if_dout is don't-care while if_empty_n=0.
- DEPTH=1 is legal: full_n and empty_n are mutually exclusive after reset.

Decomposition:
- Shared package pe_fifo_pkg:
  - function clog2.
  - localparams for the default token width and depth used by PE start FIFOs.
  - count-width helper ADDR_WIDTH+1.
- One sub-module, pe_start_srl_fifo_shiftreg: storage array with ports clk, we, addr, din, dout. It has no reset and holds no control logic.
- The control (count, flags, handshake) lives in the top module.

Test Plan:
- Reset hold: ap_rst_n=0 for 3 cycles, if_write=1 -> if_full_n=0, if_empty_n=0, if_count=0, no word stored. After release, if_full_n=1 one cycle later.
- Fill/drain, DATA_WIDTH=8, DEPTH=2: push 0xA1, then 0xB2 -> if_count=2, if_full_n=0. Third push 0xC3 is ignored. Pops return 0xA1 then 0xB2, then if_empty_n=0.
- Fall-through: push 0x5E at edge N into an empty FIFO -> if_empty_n=1 and if_dout=0x5E after edge N. Pop in the next cycle -> empty after that edge.
- Simultaneous push & pop with 1 word (0x11) held, pushing 0x22 -> if_count stays 1, if_dout=0x22. Repeat 10 cycles with an incrementing pattern -> strict FIFO order, no loss.
- Full plus both requests: full with 0x01, 0x02, push 0x03 and pop at the same time -> 0x01 is popped, 0x03 is dropped, if_count=1, if_dout=0x02.
- Clock enables and mid-run reset: if_read_ce=0 with if_read=1 -> no pop. Reset asserted with 2 words held -> after release if_count=0 and if_empty_n=0.
